adc_seq_ctrl: RTL

- Multi-channel conversion scheduler for the differential SAR ADC core.
- Owns the analog input mux select and the ADC start pulse. Detects conversion completion from the ADC ready level.
- Runs scan rounds over an enabled-channel mask, triggered by a periodic timer or a software trigger.
- Presents each result with its channel tag through a one-deep valid/ready output register toward the digital back end.

---
 rtl/adc_seq_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_seq_ctrl.sv
// Multi-channel SAR ADC scan sequencer: mux select, start pulse, rdy-edge capture, 1-deep result register.
// Optional macro ADC_SEQ_TIMEOUT_EN adds a WAIT timeout that skips a hung channel and flags timeout_o.
module adc_seq_ctrl #(
  parameter int RESOLUTION    = 8,
  parameter int NUM_CH        = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMER_W       = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [TIMER_W-1:0]        period_i,
  input  logic                      trig_i,
  input  logic [NUM_CH-1:0]         ch_mask_i,
  output logic                      adc_start_o,
  input  logic                      adc_rdy_i,
  input  logic [RESOLUTION-1:0]     adc_result_i,
  output logic [$clog2(NUM_CH)-1:0] mux_sel_o,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [RESOLUTION-1:0]     res_data_o,
  output logic [$clog2(NUM_CH)-1:0] res_ch_o,
  output logic                      busy_o,
  output logic                      overrun_o,
  input  logic                      clr_overrun_i
`ifdef ADC_SEQ_TIMEOUT_EN
  ,
  output logic                      timeout_o
`endif
);

  localparam int CH_W      = $clog2(NUM_CH);
  localparam int TO_CYCLES = RESOLUTION + 8;
  localparam int CNT_MAX   = (TO_CYCLES > SETTLE_CYCLES) ? TO_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, OUT} state_e;

  state_e                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic [CH_W-1:0]       sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rdy_prev_q, rdy_prev_d;
  logic [RESOLUTION-1:0] cap_q, cap_d;
  logic                  vld_q, vld_d;
  logic [RESOLUTION-1:0] data_q, data_d;
  logic [CH_W-1:0]       ch_q, ch_d;
`ifdef ADC_SEQ_TIMEOUT_EN
  logic                  timeout_q, timeout_d;
`endif

  logic timer_run, tick, trig, rdy_edge, start_rnd, ovr_set, to_set, advance;

  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = '0;
    for (int k = NUM_CH-1; k >= 0; k--) if (m[k]) lowest = CH_W'(k);
  endfunction

  always_comb begin
    timer_run = en_i && (period_i != '0);
    tick      = timer_run && (timer_q == period_i - TIMER_W'(1));
    timer_d   = (!timer_run || tick) ? '0 : timer_q + TIMER_W'(1);
    trig      = tick || trig_i;
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    mask_d     = mask_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    vld_d      = vld_q;
    data_d     = data_q;
    ch_d       = ch_q;
    rdy_prev_d = adc_rdy_i;
    rdy_edge   = adc_rdy_i && !rdy_prev_q;
    start_rnd  = (state_q == IDLE) && (trig || pending_q);
    ovr_set    = 1'b0;
    to_set     = 1'b0;
    advance    = 1'b0;

    if (vld_q && res_ready_i) vld_d = 1'b0;

    // A trigger landing on a pending-started IDLE cycle re-arms the flag it consumes.
    if (state_q == IDLE) begin
      if (start_rnd) pending_d = pending_q && trig;
    end else if (trig) begin
      if (pending_q) ovr_set = 1'b1;
      else           pending_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start_rnd) begin
          mask_d = ch_mask_i;
          if (ch_mask_i != '0) begin
            sel_d   = lowest(ch_mask_i);
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES-1)) state_d = START;
        else                                  cnt_d   = cnt_q + CNT_W'(1);
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (rdy_edge) begin
          cap_d   = adc_result_i;
          state_d = OUT;
        end
`ifdef ADC_SEQ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TO_CYCLES-1)) begin
          to_set  = 1'b1;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      OUT: begin
        if (!vld_q || res_ready_i) begin
          vld_d   = 1'b1;
          data_d  = cap_q;
          ch_d    = sel_q;
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Channels are visited in ascending order, so the lowest remaining bit is the next higher one.
    if (advance) begin
      mask_d = mask_q & ~(NUM_CH'(1) << sel_q);
      if (mask_d != '0) begin
        sel_d   = lowest(mask_d);
        cnt_d   = '0;
        state_d = SETTLE;
      end else begin
        state_d = IDLE;
      end
    end

    overrun_d = ovr_set ? 1'b1 : (clr_overrun_i ? 1'b0 : overrun_q);
`ifdef ADC_SEQ_TIMEOUT_EN
    timeout_d = to_set ? 1'b1 : (clr_overrun_i ? 1'b0 : timeout_q);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      mask_q     <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      rdy_prev_q <= 1'b0;
      cap_q      <= '0;
      vld_q      <= 1'b0;
      data_q     <= '0;
      ch_q       <= '0;
`ifdef ADC_SEQ_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      mask_q     <= mask_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      rdy_prev_q <= rdy_prev_d;
      cap_q      <= cap_d;
      vld_q      <= vld_d;
      data_q     <= data_d;
      ch_q       <= ch_d;
`ifdef ADC_SEQ_TIMEOUT_EN
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign adc_start_o = (state_q == START);
  assign busy_o      = (state_q != IDLE);
  assign mux_sel_o   = sel_q;
  assign res_valid_o = vld_q;
  assign res_data_o  = data_q;
  assign res_ch_o    = ch_q;
  assign overrun_o   = overrun_q;
`ifdef ADC_SEQ_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`endif

endmodule
